// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, keypad map and scanner state shared by the calculator
package calc_pkg;

  localparam logic [3:0] KEY_EQUAL = 4'hA;
  localparam logic [3:0] KEY_AC    = 4'hB;
  localparam logic [3:0] KEY_PLUS  = 4'hC;
  localparam logic [3:0] KEY_MINUS = 4'hD;
  localparam logic [3:0] KEY_MULT  = 4'hE;
  localparam logic [3:0] KEY_DIV   = 4'hF;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    EMIT,
    WAIT_RELEASE
  } scan_state_t;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    k = 4'h0;
    case ({row, col})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = KEY_PLUS;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = KEY_MINUS;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = KEY_MULT;
      4'b11_00: k = KEY_AC;
      4'b11_01: k = 4'h0;
      4'b11_10: k = KEY_EQUAL;
      4'b11_11: k = KEY_DIV;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous board inputs
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       kbEN,
  output logic [3:0] pressedkey
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rs;
  scan_state_t   state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    col;
  logic [1:0]    row;
  logic [3:0]    pattern;
  logic          one_low;
  logic [1:0]    low_row;
  logic [1:0]    col_next;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rs)
  );

  // Only a single low row is a usable key; several low rows are ambiguous.
  always_comb begin
    one_low = 1'b0;
    low_row = 2'd0;
    case (rs)
      4'b1110: begin one_low = 1'b1; low_row = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_row = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_row = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_row = 2'd3; end
      default: begin one_low = 1'b0; low_row = 2'd0; end
    endcase
  end

  assign col_next = col + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      col        <= 2'd0;
      col_n      <= 4'b1110;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      row        <= 2'd0;
      pattern    <= 4'b1111;
      kbEN       <= 1'b0;
      pressedkey <= 4'h0;
    end else begin
      kbEN <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (one_low) begin
              state   <= DEBOUNCE_PRESS;
              row     <= low_row;
              pattern <= rs;
              deb_cnt <= '0;
            end else begin
              col   <= col_next;
              col_n <= ~(4'b0001 << col_next);
            end
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        DEBOUNCE_PRESS: begin
          if (rs != pattern) begin
            state    <= SCAN;
            col      <= col_next;
            col_n    <= ~(4'b0001 << col_next);
            scan_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state      <= EMIT;
            kbEN       <= 1'b1;
            pressedkey <= keymap(row, col);
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        EMIT: begin
          state   <= WAIT_RELEASE;
          deb_cnt <= '0;
        end
        WAIT_RELEASE: begin
          // Column stays put, so keys in other columns are invisible here.
          if (rs != 4'b1111) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= SCAN;
            col      <= col_next;
            col_n    <= ~(4'b0001 << col_next);
            scan_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized and directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SD      = 4;
  localparam int DB      = 8;
  localparam int SPACING = 2 * DB + SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       kbEN;
  logic [3:0] pressedkey;

  logic       pressed [4][4];
  logic [3:0] km      [4][4];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd = 0;
  int strobe_count = 0;
  int last_strobe = -1;
  int exp_codes[$];
  int log_codes[$];
  logic [3:0] last_code = 4'h0;
  logic prev_ken = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .kbEN       (kbEN),
    .pressedkey (pressedkey)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && col_n[c] == 1'b0) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic r;
    @(posedge clk);
    r = rst;
    cyc++;
    @(negedge clk);
    if (r) begin
      chk("rst_col_n", col_n, 4'b1110);
      chk("rst_kbEN", kbEN, 1'b0);
      chk("rst_pressedkey", pressedkey, 4'h0);
      last_code   = 4'h0;
      prev_ken    = 1'b0;
      last_strobe = -1;
    end else begin
      chk("col_one_hot", $countones(~col_n), 1);
      if (kbEN) begin
        chk("no_back_to_back", prev_ken, 1'b0);
        if (last_strobe >= 0) chk("strobe_spacing", (cyc - last_strobe) >= SPACING, 1'b1);
        if (rd < exp_codes.size()) begin
          chk("strobe_code", pressedkey, exp_codes[rd]);
          last_code = 4'(exp_codes[rd]);
          rd++;
        end else begin
          chk("unexpected_strobe", kbEN, 1'b0);
        end
        log_codes.push_back(int'(pressedkey));
        last_strobe = cyc;
        strobe_count++;
      end else begin
        chk("pressedkey_held", pressedkey, last_code);
      end
      prev_ken = kbEN;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_strobe(input int bound);
    int s0 = strobe_count;
    int n = 0;
    while (strobe_count == s0 && n < bound) begin
      tick();
      n++;
    end
    chk("strobe_timeout", strobe_count, s0 + 1);
  endtask

  task automatic wait_col(input logic [3:0] val, input int bound);
    int n = 0;
    while (col_n !== val && n < bound) begin
      tick();
      n++;
    end
    chk("wait_col", col_n, val);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  // Minimal calculator front end: digits build an operand, operators fold left to right.
  function automatic int calc(input int from);
    int acc = 0;
    int cur = 0;
    int op = -1;
    int disp = 0;
    for (int i = from; i < log_codes.size(); i++) begin
      int k = log_codes[i];
      if (k <= 9) begin
        cur = cur * 10 + k;
        disp = cur;
      end else if (k == 11) begin
        acc = 0; cur = 0; op = -1; disp = 0;
      end else begin
        case (op)
          12: acc = acc + cur;
          13: acc = acc - cur;
          14: acc = acc * cur;
          15: acc = (cur != 0) ? acc / cur : 0;
          default: acc = cur;
        endcase
        disp = acc;
        cur = 0;
        op = (k == 10) ? -1 : k;
      end
    end
    return disp;
  endfunction

  initial begin
    int n;
    int base;
    int seq_r[4];
    int seq_c[4];
    km[0][0] = 4'h1; km[0][1] = 4'h2; km[0][2] = 4'h3; km[0][3] = 4'hC;
    km[1][0] = 4'h4; km[1][1] = 4'h5; km[1][2] = 4'h6; km[1][3] = 4'hD;
    km[2][0] = 4'h7; km[2][1] = 4'h8; km[2][2] = 4'h9; km[2][3] = 4'hE;
    km[3][0] = 4'hB; km[3][1] = 4'h0; km[3][2] = 4'hA; km[3][3] = 4'hF;
    release_all();

    // Reset with (0,0) held, then a single press and release.
    pressed[0][0] = 1'b1;
    rst = 1'b1;
    idle(3);
    exp_codes.push_back(1);
    rst = 1'b0;
    n = 0;
    while (kbEN !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("press_latency_after_reset", n, 12);
    chk("first_code_literal", pressedkey, 4'h1);
    idle(40 - n);
    pressed[0][0] = 1'b0;
    n = 0;
    while (col_n === 4'b1110 && n < 60) begin
      tick();
      n++;
    end
    chk("resume_next_col", col_n, 4'b1101);
    chk("single_press_count", strobe_count, 1);

    // 1 + 1 = through a small calculator.
    idle(20);
    base = log_codes.size();
    seq_r = '{0, 0, 0, 3};
    seq_c = '{0, 3, 0, 2};
    for (int i = 0; i < 4; i++) begin
      exp_codes.push_back(int'(km[seq_r[i]][seq_c[i]]));
      pressed[seq_r[i]][seq_c[i]] = 1'b1;
      idle(40);
      pressed[seq_r[i]][seq_c[i]] = 1'b0;
      idle(40);
    end
    chk("sequence_all_seen", rd, exp_codes.size());
    chk("calc_display", calc(base), 2);

    // Contact bounce on (3,0) followed by a clean hold.
    for (int i = 0; i < 20; i++) begin
      pressed[3][0] = ((i / 3) % 2 == 0);
      tick();
    end
    pressed[3][0] = 1'b1;
    exp_codes.push_back(int'(km[3][0]));
    idle(40);
    pressed[3][0] = 1'b0;
    idle(40);
    chk("bounce_one_strobe", rd, exp_codes.size());

    // No rollover while waiting for release; then (2,2) alone; then a same-column pair.
    exp_codes.push_back(int'(km[1][1]));
    pressed[1][1] = 1'b1;
    wait_strobe(80);
    idle(4);
    pressed[2][2] = 1'b1;
    idle(20);
    release_all();
    idle(40);
    chk("rollover_suppressed", rd, exp_codes.size());
    exp_codes.push_back(int'(km[2][2]));
    pressed[2][2] = 1'b1;
    idle(40);
    pressed[2][2] = 1'b0;
    idle(40);
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    idle(60);
    release_all();
    idle(40);
    chk("ambiguous_no_strobe", rd, exp_codes.size());

    // Reset during debounce of (3,3); key still held afterwards.
    wait_col(4'b1110, 40);
    pressed[3][3] = 1'b1;
    wait_col(4'b0111, 40);
    idle(5);
    rst = 1'b1;
    idle(2);
    chk("no_strobe_before_reset", strobe_count, exp_codes.size());
    exp_codes.push_back(int'(km[3][3]));
    rst = 1'b0;
    wait_strobe(80);
    chk("repress_code_literal", pressedkey, 4'hF);
    pressed[3][3] = 1'b0;
    idle(40);

    // Randomized single presses.
    for (int i = 0; i < 12; i++) begin
      int r = int'($urandom_range(3, 0));
      int c = int'($urandom_range(3, 0));
      exp_codes.push_back(int'(km[r][c]));
      pressed[r][c] = 1'b1;
      idle(40 + int'($urandom_range(20, 0)));
      pressed[r][c] = 1'b0;
      idle(30 + int'($urandom_range(20, 0)));
    end
    chk("random_all_seen", rd, exp_codes.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
